// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared states, seeds and mode encodings for the Fibonacci-class term generator
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_LUC = 1'b1;

    localparam int FIB_SEED0 = 0;
    localparam int FIB_SEED1 = 1;
    localparam int LUC_SEED0 = 2;
    localparam int LUC_SEED1 = 1;

endpackage

// File: rtl/fib_step.sv
// rtl/fib_step.sv - combinational W-bit next-term adder with carry out
module fib_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - iterative Fibonacci/Lucas term generator with start/busy request and valid/ready result
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int W  = 16,
    parameter int NW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic          mode,
    output logic          busy,
    output logic [W-1:0]  result,
    output logic          overflow,
    output logic          valid,
    input  logic          ready
);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, b_q;
    logic [NW-1:0] cnt_q;
    logic          ova_q, ovb_q;
    logic [W-1:0]  sum;
    logic          carry;

    fib_step #(.W(W)) u_step (
        .a     (a_q),
        .b     (b_q),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // a holds the current term, b the next; ova/ovb record whether their true values exceed W bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            ova_q    <= 1'b0;
            ovb_q    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= n;
                        a_q   <= (mode == MODE_LUC) ? W'(LUC_SEED0) : W'(FIB_SEED0);
                        b_q   <= (mode == MODE_LUC) ? W'(LUC_SEED1) : W'(FIB_SEED1);
                        ova_q <= 1'b0;
                        ovb_q <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        result   <= a_q;
                        overflow <= ova_q;
                    end else begin
                        a_q   <= b_q;
                        ova_q <= ovb_q;
                        b_q   <= sum;
                        ovb_q <= ovb_q | ova_q | carry;
                        cnt_q <= cnt_q - NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (state_q == DONE);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - randomized self-checking bench for fib_seq_gen against a sequence-definition model
module tb_fib_seq_gen;

    localparam int W  = 16;
    localparam int NW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] n;
    logic          mode;
    logic          busy;
    logic [W-1:0]  result;
    logic          overflow;
    logic          valid;
    logic          ready;

    int checks = 0;
    int errors = 0;

    fib_seq_gen #(.W(W), .NW(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n        (n),
        .mode     (mode),
        .busy     (busy),
        .result   (result),
        .overflow (overflow),
        .valid    (valid),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    // Exact term from the recurrence in wide arithmetic
    function automatic longint unsigned ref_term(input int idx, input logic md);
        longint unsigned t0, t1, t2;
        t0 = md ? 2 : 0;
        t1 = 1;
        for (int i = 0; i < idx; i++) begin
            t2 = t0 + t1;
            t0 = t1;
            t1 = t2;
        end
        return t0;
    endfunction

    function automatic logic [W-1:0] ref_low(input int idx, input logic md);
        longint unsigned v;
        v = ref_term(idx, md);
        return v[W-1:0];
    endfunction

    function automatic logic ref_ovf(input int idx, input logic md);
        return ref_term(idx, md) >= (64'd1 << W);
    endfunction

    // Issues one request from a negedge; returns at the negedge where valid is first seen (lat = -1 on timeout)
    task automatic do_req(input int idx, input logic md, output int lat);
        n     = NW'(idx);
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n     = NW'($urandom);
        mode  = 1'($urandom);
        lat   = -1;
        if (valid) begin
            lat = 0;
        end else begin
            for (int c = 1; c <= 100; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (valid) begin
                    lat = c;
                    break;
                end
            end
        end
    endtask

    task automatic finish_hs();
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        mode  = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, valid, overflow, result} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b ovf=%b result=%0d, required 0 0 0 0",
                     busy, valid, overflow, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fib_basic();
        int lat;
        int idxs[3] = '{0, 1, 9};
        foreach (idxs[i]) begin
            do_req(idxs[i], 1'b0, lat);
            checks++;
            if (lat !== idxs[i] + 1 || result !== ref_low(idxs[i], 1'b0) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL fib_basic n=%0d: lat=%0d result=%0d ovf=%b, required lat=%0d result=%0d ovf=0",
                         idxs[i], lat, result, overflow, idxs[i] + 1, ref_low(idxs[i], 1'b0));
            end
            finish_hs();
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL fib_basic_hs n=%0d: valid=%b busy=%b, required 0 0", idxs[i], valid, busy);
            end
        end
    endtask

    task automatic test_sweep(input logic md, input int last);
        int lat;
        for (int k = 0; k <= last; k++) begin
            do_req(k, md, lat);
            checks++;
            if (lat !== k + 1 || result !== ref_low(k, md) || overflow !== ref_ovf(k, md)) begin
                errors++;
                $display("FAIL sweep mode=%b n=%0d: lat=%0d result=%0d ovf=%b, required lat=%0d result=%0d ovf=%b",
                         md, k, lat, result, overflow, k + 1, ref_low(k, md), ref_ovf(k, md));
            end
            finish_hs();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        ready = 1'b0;
        do_req(6, 1'b0, lat);
        checks++;
        if (lat !== 7 || result !== 16'd8) begin
            errors++;
            $display("FAIL bp_first: lat=%0d result=%0d, required lat=7 result=8", lat, result);
        end
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            n     = 5'd3;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || result !== 16'd8 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d: valid=%b busy=%b result=%0d, required 1 1 8", c, valid, busy, result);
            end
        end
        // start coincident with the handshake must also be dropped
        start = 1'b1;
        finish_hs();
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b, required 0 0", valid, busy);
        end
        do_req(3, 1'b0, lat);
        checks++;
        if (lat !== 4 || result !== 16'd2) begin
            errors++;
            $display("FAIL bp_next: lat=%0d result=%0d, required lat=4 result=2", lat, result);
        end
        finish_hs();
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen = 0;
        n     = 5'd20;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, valid, overflow, result} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b ovf=%b result=%0d, required 0 0 0 0",
                     busy, valid, overflow, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: activity cycles=%0d, required 0", seen);
        end
        do_req(7, 1'b0, lat);
        checks++;
        if (lat !== 8 || result !== 16'd13) begin
            errors++;
            $display("FAIL mid_reset_next: lat=%0d result=%0d, required lat=8 result=13", lat, result);
        end
        finish_hs();
    endtask

    task automatic test_wrap();
        int lat;
        do_req(31, 1'b0, lat);
        checks++;
        if (lat !== 32 || overflow !== 1'b1 || result !== ref_low(31, 1'b0)) begin
            errors++;
            $display("FAIL wrap n=31: lat=%0d result=%0d ovf=%b, required lat=32 result=%0d ovf=1",
                     lat, result, overflow, ref_low(31, 1'b0));
        end
        finish_hs();
    endtask

    task automatic test_random();
        int lat, k, dly;
        logic md;
        for (int r = 0; r < 30; r++) begin
            k   = $urandom_range(0, 31);
            md  = 1'($urandom);
            dly = $urandom_range(0, 3);
            ready = (dly == 0);
            do_req(k, md, lat);
            repeat (dly) begin
                @(posedge clk);
                @(negedge clk);
            end
            checks++;
            if (lat !== k + 1 || valid !== 1'b1 || result !== ref_low(k, md) || overflow !== ref_ovf(k, md)) begin
                errors++;
                $display("FAIL random mode=%b n=%0d: lat=%0d valid=%b result=%0d ovf=%b, required lat=%0d result=%0d ovf=%b",
                         md, k, lat, valid, result, overflow, k + 1, ref_low(k, md), ref_ovf(k, md));
            end
            finish_hs();
            if ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fib_basic();
        test_sweep(1'b0, 25);
        test_sweep(1'b1, 10);
        test_backpressure();
        test_reset_mid_calc();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
